operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- Decode/operand-fetch stage. Sits between the IF/ID register and the execute unit, directly upstream of the execute stage.
- Drives both read ports of the 32x32 register file and merges the returned data with forwarded EX and MEM results.
- Detects load-use hazards and registers the resolved operands into the ID/EX pipeline register.
- The register file writes on the falling clock edge, so same-cycle WB data is already visible on its read ports. WB forwarding is therefore not done here.

Parameters:
- LINK_OFFSET, 8: value added to id_pc to form the JAL/JALR link operand.
- LINK_REGISTER, 31: destination register index for JAL.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registered outputs
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  32  PC of the instruction in ID
- id_instruction  in  32  raw instruction word
- rf_read_enable_a  out  1  register file port A enable (rs)
- rf_read_address_a  out  5  rs field
- rf_read_data_a  in  32  port A data (combinational return)
- rf_read_enable_b  out  1  register file port B enable (rt)
- rf_read_address_b  out  5  rt field
- rf_read_data_b  in  32  port B data
- fwd_ex_write_enable  in  1  EX-stage instruction will write a register
- fwd_ex_write_address  in  5  EX-stage destination
- fwd_ex_write_data  in  32  EX-stage ALU result
- fwd_ex_is_load  in  1  EX-stage instruction is a load (data not yet available)
- fwd_mem_write_enable  in  1  MEM-stage instruction will write a register
- fwd_mem_write_address  in  5  MEM-stage destination
- fwd_mem_write_data  in  32  MEM-stage result (load data included)
- stall_in  in  1  downstream stall; hold ID/EX
- flush  in  1  kill the instruction in ID (branch redirect/exception)
- stall_request  out  1  combinational; IF/ID must hold its contents
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  32
- ex_instruction  out  32
- ex_operand_a  out  32  resolved rs value (or link value)
- ex_operand_b  out  32  resolved rt value
- ex_immediate  out  32  extended immediate
- ex_write_enable  out  1
- ex_write_address  out  5

Behaviour:
- Source enables (combinational, from opcode/funct):
  - rs read for all instructions except J, JAL and LUI.
  - rt read for R-type, BEQ, BNE and stores.
  - Both enables are 0 when id_valid=0.
- Destination:
  - R-type writes rd, except JR, which has no write.
  - I-type ALU ops and loads write rt.
  - JAL writes LINK_REGISTER; JALR writes rd.
  - Stores and branches have no write.
  - Destination 0 forces ex_write_enable=0.
- Immediate:
  - Sign-extend for ADDI/ADDIU/SLTI/SLTIU, loads, stores and branches.
  - Zero-extend for ANDI/ORI/XORI.
  - LUI: immediate shifted left by 16.
- Operand resolution, per port, in priority order:
  1. Address 0 or enable 0 gives 0.
  2. EX match with fwd_ex_write_enable=1 gives fwd_ex_write_data.
  3. MEM match gives fwd_mem_write_data.
  4. Otherwise the rf read data.
- JAL/JALR: ex_operand_a = id_pc + LINK_OFFSET (32-bit wrap).
- Load-use hazard: asserted when fwd_ex_is_load=1, fwd_ex_write_enable=1, the EX address is nonzero and it equals an enabled source address.
  - stall_request=1 in the same cycle.
  - At the next rising edge, ID/EX takes a bubble.
- Bubble: ex_valid=0, ex_write_enable=0, all other ex_* fields 0.
- ID/EX update at the rising edge, in priority order:
  1. reset: all outputs 0.
  2. flush: bubble (overrides stall_in and the hazard).
  3. stall_in: hold all ex_* values.
  4. Hazard: bubble.
  5. Otherwise capture the decoded instruction; ex_valid = id_valid.
- stall_request = stall_in OR hazard. Flush does not raise it.
- Reset asserted mid-operation clears ID/EX immediately (asynchronous).
- Reset has no effect on the combinational rf_* outputs.
- Single-cycle latency ID to EX when no stall is present.

Decomposition:
- Shared package holds:
  - opcode and funct constants
  - enable/disable constants already in use (write/read enable, reset levels)
  - immediate-kind enumeration (sign, zero, upper)
- One sub-module, operand_forward: the combinational 3-way forward mux, instantiated once per port.
- Decode and the pipeline register stay in operand_stage.

Test Plan:
- Plain read: ADDU $3,$1,$2 with rf returning 5 and 7, no forwarding active -> next edge ex_operand_a=5, ex_operand_b=7, ex_write_address=3, ex_valid=1.
- EX priority: EX writes $1=0xAA while MEM also writes $1=0xBB -> ex_operand_a=0xAA. Same case with the EX write disabled -> 0xBB.
- Load-use: LW $4 in EX with fwd_ex_is_load=1, then ADDU $5,$4,$4 in ID -> stall_request=1 and next edge ex_valid=0. The cycle after, with MEM forwarding $4=0x1234 -> ex_operand_a=ex_operand_b=0x1234.
- $0 immunity: EX writing $0 with 0xFFFF, ID reading $0 -> operand 0 and no stall, including when EX is a load.
- Flush beats stall: flush=1 and stall_in=1 together -> next edge ex_valid=0. stall_in=1 alone -> all ex_* unchanged for 3 cycles.
- JAL at id_pc=0x00400010 -> ex_operand_a=0x00400018, ex_write_address=31. Async reset pulse mid-cycle -> ex_valid=0 immediately.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// operand_stage_pkg: shared constants and types for the decode/operand-fetch stage.
//   - MIPS opcode / funct field values recognised by the decoder
//   - enable/disable levels for register-file and write-back controls
//   - immediate-kind enumeration and the ID/EX payload struct
package operand_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes with special handling
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;

    // Control levels
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic RESET_ACTIVE  = 1'b1;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_SIGN,
        IMM_ZERO,
        IMM_UPPER
    } imm_kind_t;

    // ID/EX register contents; an all-zero value is a bubble
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] immediate;
        logic        write_enable;
        logic [4:0]  write_address;
    } idex_t;

    function automatic logic [31:0] extend_imm(input imm_kind_t kind, input logic [15:0] imm);
        case (kind)
            IMM_SIGN:  extend_imm = {{16{imm[15]}}, imm};
            IMM_ZERO:  extend_imm = {16'h0000, imm};
            IMM_UPPER: extend_imm = {imm, 16'h0000};
            default:   extend_imm = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/operand_stage_forward.sv
// operand_forward: 3-way forward mux for one register-file read port.
//   read_enable/read_address : source request for this port
//   rf_read_data             : data returned by the register file
//   ex_* / mem_*             : in-flight results of the EX and MEM stages
//   operand                  : resolved value (0 for $0 or an unused port)
// The younger EX result wins over MEM. WB is not needed: the register file
// writes on the falling edge, so its read data already carries it.
module operand_forward (
    input  logic        read_enable,
    input  logic [4:0]  read_address,
    input  logic [31:0] rf_read_data,
    input  logic        ex_write_enable,
    input  logic [4:0]  ex_write_address,
    input  logic [31:0] ex_write_data,
    input  logic        mem_write_enable,
    input  logic [4:0]  mem_write_address,
    input  logic [31:0] mem_write_data,
    output logic [31:0] operand
);
    always_comb begin
        operand = rf_read_data;
        if (!read_enable || read_address == 5'd0)
            operand = 32'h0;
        else if (ex_write_enable && ex_write_address == read_address)
            operand = ex_write_data;
        else if (mem_write_enable && mem_write_address == read_address)
            operand = mem_write_data;
    end
endmodule

// File: rtl/operand_stage.sv
// operand_stage: decode / operand-fetch stage feeding the ID/EX register.
//   clock, reset          : rising-edge clock, async active-high reset
//   id_*                  : instruction held in IF/ID
//   rf_read_*_a/_b        : register file read ports (rs / rt)
//   fwd_ex_*, fwd_mem_*   : forwarding sources from EX and MEM
//   stall_in, flush       : downstream hold / kill of the ID instruction
//   stall_request         : IF/ID must hold (downstream stall or load-use)
//   ex_*                  : ID/EX pipeline register outputs
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int unsigned LINK_OFFSET   = 8,
    parameter int unsigned LINK_REGISTER = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_instruction,
    output logic        rf_read_enable_a,
    output logic [4:0]  rf_read_address_a,
    input  logic [31:0] rf_read_data_a,
    output logic        rf_read_enable_b,
    output logic [4:0]  rf_read_address_b,
    input  logic [31:0] rf_read_data_b,
    input  logic        fwd_ex_write_enable,
    input  logic [4:0]  fwd_ex_write_address,
    input  logic [31:0] fwd_ex_write_data,
    input  logic        fwd_ex_is_load,
    input  logic        fwd_mem_write_enable,
    input  logic [4:0]  fwd_mem_write_address,
    input  logic [31:0] fwd_mem_write_data,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stall_request,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_instruction,
    output logic [31:0] ex_operand_a,
    output logic [31:0] ex_operand_b,
    output logic [31:0] ex_immediate,
    output logic        ex_write_enable,
    output logic [4:0]  ex_write_address
);
    localparam int NUM_PORTS = 2;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        use_rs, use_rt, dest_we, is_link;
    logic [4:0]  dest;
    imm_kind_t   imm_kind;

    assign opcode = id_instruction[31:26];
    assign rs     = id_instruction[25:21];
    assign rt     = id_instruction[20:16];
    assign rd     = id_instruction[15:11];
    assign funct  = id_instruction[5:0];

    always_comb begin
        use_rs   = READ_ENABLE;
        use_rt   = READ_DISABLE;
        dest_we  = WRITE_DISABLE;
        dest     = 5'd0;
        is_link  = 1'b0;
        imm_kind = IMM_NONE;
        case (opcode)
            OP_RTYPE: begin
                use_rt = READ_ENABLE;
                if (funct != FN_JR) begin
                    dest_we = WRITE_ENABLE;
                    dest    = rd;
                end
                is_link = (funct == FN_JALR);
            end
            OP_J:   use_rs = READ_DISABLE;
            OP_JAL: begin
                use_rs  = READ_DISABLE;
                dest_we = WRITE_ENABLE;
                dest    = 5'(LINK_REGISTER);
                is_link = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                use_rt   = READ_ENABLE;
                imm_kind = IMM_SIGN;
            end
            OP_BLEZ, OP_BGTZ, OP_REGIMM: imm_kind = IMM_SIGN;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dest_we  = WRITE_ENABLE;
                dest     = rt;
                imm_kind = IMM_SIGN;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dest_we  = WRITE_ENABLE;
                dest     = rt;
                imm_kind = IMM_ZERO;
            end
            OP_LUI: begin
                use_rs   = READ_DISABLE;
                dest_we  = WRITE_ENABLE;
                dest     = rt;
                imm_kind = IMM_UPPER;
            end
            OP_SB, OP_SH, OP_SW: begin
                use_rt   = READ_ENABLE;
                imm_kind = IMM_SIGN;
            end
            default: ;
        endcase
    end

    assign rf_read_enable_a  = id_valid & use_rs;
    assign rf_read_enable_b  = id_valid & use_rt;
    assign rf_read_address_a = rs;
    assign rf_read_address_b = rt;

    // Port 0 = rs (A), port 1 = rt (B)
    logic [NUM_PORTS-1:0]       src_en;
    logic [NUM_PORTS-1:0][4:0]  src_addr;
    logic [NUM_PORTS-1:0][31:0] src_data;
    logic [NUM_PORTS-1:0][31:0] src_op;

    assign src_en   = {rf_read_enable_b, rf_read_enable_a};
    assign src_addr = {rf_read_address_b, rf_read_address_a};
    assign src_data = {rf_read_data_b, rf_read_data_a};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fwd
        operand_forward u_fwd (
            .read_enable       (src_en[p]),
            .read_address      (src_addr[p]),
            .rf_read_data      (src_data[p]),
            .ex_write_enable   (fwd_ex_write_enable),
            .ex_write_address  (fwd_ex_write_address),
            .ex_write_data     (fwd_ex_write_data),
            .mem_write_enable  (fwd_mem_write_enable),
            .mem_write_address (fwd_mem_write_address),
            .mem_write_data    (fwd_mem_write_data),
            .operand           (src_op[p])
        );
    end

    // Load data is not available until MEM; any enabled source matching a
    // nonzero load destination in EX must wait one cycle.
    logic hazard;
    always_comb begin
        hazard = 1'b0;
        if (fwd_ex_is_load && fwd_ex_write_enable && fwd_ex_write_address != 5'd0)
            for (int p = 0; p < NUM_PORTS; p++)
                if (src_en[p] && src_addr[p] == fwd_ex_write_address)
                    hazard = 1'b1;
    end

    assign stall_request = stall_in | hazard;

    logic  final_we;
    idex_t cap, idex_q;

    assign final_we = id_valid & dest_we & (dest != 5'd0);

    always_comb begin
        cap               = '0;
        cap.valid         = id_valid;
        cap.pc            = id_pc;
        cap.instruction   = id_instruction;
        cap.operand_a     = is_link ? id_pc + 32'(LINK_OFFSET) : src_op[0];
        cap.operand_b     = src_op[1];
        cap.immediate     = extend_imm(imm_kind, id_instruction[15:0]);
        cap.write_enable  = final_we;
        cap.write_address = final_we ? dest : 5'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ACTIVE) idex_q <= '0;
        else if (flush)            idex_q <= '0;
        else if (stall_in)         idex_q <= idex_q;
        else if (hazard)           idex_q <= '0;
        else                       idex_q <= cap;
    end

    assign ex_valid         = idex_q.valid;
    assign ex_pc            = idex_q.pc;
    assign ex_instruction   = idex_q.instruction;
    assign ex_operand_a     = idex_q.operand_a;
    assign ex_operand_b     = idex_q.operand_b;
    assign ex_immediate     = idex_q.immediate;
    assign ex_write_enable  = idex_q.write_enable;
    assign ex_write_address = idex_q.write_address;

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;
    logic        clock, reset;
    logic        id_valid;
    logic [31:0] id_pc, id_instruction;
    logic        rf_read_enable_a, rf_read_enable_b;
    logic [4:0]  rf_read_address_a, rf_read_address_b;
    logic [31:0] rf_read_data_a, rf_read_data_b;
    logic        fwd_ex_write_enable, fwd_ex_is_load;
    logic [4:0]  fwd_ex_write_address;
    logic [31:0] fwd_ex_write_data;
    logic        fwd_mem_write_enable;
    logic [4:0]  fwd_mem_write_address;
    logic [31:0] fwd_mem_write_data;
    logic        stall_in, flush, stall_request;
    logic        ex_valid, ex_write_enable;
    logic [31:0] ex_pc, ex_instruction, ex_operand_a, ex_operand_b, ex_immediate;
    logic [4:0]  ex_write_address;

    int total = 0;
    int bad   = 0;

    operand_stage dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instruction),
        .rf_read_enable_a(rf_read_enable_a), .rf_read_address_a(rf_read_address_a),
        .rf_read_data_a(rf_read_data_a),
        .rf_read_enable_b(rf_read_enable_b), .rf_read_address_b(rf_read_address_b),
        .rf_read_data_b(rf_read_data_b),
        .fwd_ex_write_enable(fwd_ex_write_enable), .fwd_ex_write_address(fwd_ex_write_address),
        .fwd_ex_write_data(fwd_ex_write_data), .fwd_ex_is_load(fwd_ex_is_load),
        .fwd_mem_write_enable(fwd_mem_write_enable), .fwd_mem_write_address(fwd_mem_write_address),
        .fwd_mem_write_data(fwd_mem_write_data),
        .stall_in(stall_in), .flush(flush), .stall_request(stall_request),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instruction(ex_instruction),
        .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
        .ex_immediate(ex_immediate), .ex_write_enable(ex_write_enable),
        .ex_write_address(ex_write_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic [31:0] pc, instr, rfa, rfb;
        logic        exwe;
        logic [4:0]  exaddr;
        logic [31:0] exdata;
        logic        exld, memwe;
        logic [4:0]  memaddr;
        logic [31:0] memdata;
        // expected
        logic        en_a, en_b, stall, ev;
        logic [31:0] opa, opb, imm;
        logic        we;
        logic [4:0]  waddr;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] fn);
        rtype = {6'h00, s, t, d, 5'd0, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                          input logic [15:0] im);
        itype = {op, s, t, im};
    endfunction

    function automatic vec_t mk(input logic valid, input logic [31:0] pc, instr, rfa, rfb,
                                input logic en_a, en_b, stall, ev,
                                input logic [31:0] opa, opb, imm,
                                input logic we, input logic [4:0] waddr);
        vec_t v;
        v.valid = valid; v.pc = pc; v.instr = instr; v.rfa = rfa; v.rfb = rfb;
        v.exwe = 0; v.exaddr = 0; v.exdata = 0; v.exld = 0;
        v.memwe = 0; v.memaddr = 0; v.memdata = 0;
        v.en_a = en_a; v.en_b = en_b; v.stall = stall; v.ev = ev;
        v.opa = opa; v.opb = opb; v.imm = imm; v.we = we; v.waddr = waddr;
        return v;
    endfunction

    function automatic vec_t fw(input vec_t vi, input logic exwe, input logic [4:0] exaddr,
                                input logic [31:0] exdata, input logic exld,
                                input logic memwe, input logic [4:0] memaddr,
                                input logic [31:0] memdata);
        vec_t v = vi;
        v.exwe = exwe; v.exaddr = exaddr; v.exdata = exdata; v.exld = exld;
        v.memwe = memwe; v.memaddr = memaddr; v.memdata = memdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic st, input logic fl);
        id_valid = v.valid; id_pc = v.pc; id_instruction = v.instr;
        rf_read_data_a = v.rfa; rf_read_data_b = v.rfb;
        fwd_ex_write_enable = v.exwe; fwd_ex_write_address = v.exaddr;
        fwd_ex_write_data = v.exdata; fwd_ex_is_load = v.exld;
        fwd_mem_write_enable = v.memwe; fwd_mem_write_address = v.memaddr;
        fwd_mem_write_data = v.memdata;
        stall_in = st; flush = fl;
    endtask

    task automatic apply(input int i, input vec_t v);
        @(negedge clock);
        drive(v, 1'b0, 1'b0);
        #1;
        chk($sformatf("v%0d.en_a", i), 32'(rf_read_enable_a), 32'(v.en_a));
        chk($sformatf("v%0d.en_b", i), 32'(rf_read_enable_b), 32'(v.en_b));
        chk($sformatf("v%0d.addr_a", i), 32'(rf_read_address_a), 32'(v.instr[25:21]));
        chk($sformatf("v%0d.stall", i), 32'(stall_request), 32'(v.stall));
        @(posedge clock);
        #1;
        chk($sformatf("v%0d.ex_valid", i), 32'(ex_valid), 32'(v.ev));
        chk($sformatf("v%0d.opa", i), ex_operand_a, v.opa);
        chk($sformatf("v%0d.opb", i), ex_operand_b, v.opb);
        chk($sformatf("v%0d.imm", i), ex_immediate, v.imm);
        chk($sformatf("v%0d.we", i), 32'(ex_write_enable), 32'(v.we));
        chk($sformatf("v%0d.waddr", i), 32'(ex_write_address), 32'(v.waddr));
        chk($sformatf("v%0d.pc", i), ex_pc, v.stall ? 32'h0 : v.pc);
        chk($sformatf("v%0d.instr", i), ex_instruction, v.stall ? 32'h0 : v.instr);
    endtask

    task automatic chk_ex(input string n, input logic v, input logic [31:0] pc, instr, a, b,
                          input logic we, input logic [4:0] wa);
        chk({n, ".valid"}, 32'(ex_valid), 32'(v));
        chk({n, ".pc"}, ex_pc, pc);
        chk({n, ".instr"}, ex_instruction, instr);
        chk({n, ".opa"}, ex_operand_a, a);
        chk({n, ".opb"}, ex_operand_b, b);
        chk({n, ".we"}, 32'(ex_write_enable), 32'(we));
        chk({n, ".waddr"}, 32'(ex_write_address), 32'(wa));
    endtask

    logic [31:0] addu3, ori6;
    vec_t        base, other;

    initial begin
        addu3 = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        ori6  = itype(6'h0D, 5'd2, 5'd6, 16'h8001);

        // Table: valid pc instr rfa rfb | en_a en_b stall ev opa opb imm we waddr
        vt.push_back(mk(1, 32'h100, addu3, 5, 7, 1, 1, 0, 1, 5, 7, 0, 1, 3));
        vt.push_back(fw(mk(1, 32'h104, addu3, 5, 7, 1, 1, 0, 1, 32'hAA, 7, 0, 1, 3),
                        1, 1, 32'hAA, 0, 1, 1, 32'hBB));
        vt.push_back(fw(mk(1, 32'h108, addu3, 5, 7, 1, 1, 0, 1, 32'hBB, 7, 0, 1, 3),
                        0, 1, 32'hAA, 0, 1, 1, 32'hBB));
        vt.push_back(mk(1, 32'h10C, itype(6'h09, 5'd1, 5'd4, 16'hFFFC), 9, 32'h77,
                        1, 0, 0, 1, 9, 0, 32'hFFFFFFFC, 1, 4));
        vt.push_back(mk(1, 32'h110, ori6, 3, 32'h77, 1, 0, 0, 1, 3, 0, 32'h00008001, 1, 6));
        vt.push_back(mk(1, 32'h114, itype(6'h0F, 5'd0, 5'd7, 16'h1234), 32'h55, 32'h66,
                        0, 0, 0, 1, 0, 0, 32'h12340000, 1, 7));
        vt.push_back(mk(1, 32'h118, itype(6'h2B, 5'd1, 5'd5, 16'd16), 32'h100, 32'h200,
                        1, 1, 0, 1, 32'h100, 32'h200, 32'h10, 0, 0));
        vt.push_back(mk(1, 32'h11C, itype(6'h04, 5'd1, 5'd2, 16'hFFFF), 1, 2,
                        1, 1, 0, 1, 1, 2, 32'hFFFFFFFF, 0, 0));
        vt.push_back(mk(1, 32'h00400010, {6'h03, 26'h0100040}, 32'h11, 32'h22,
                        0, 0, 0, 1, 32'h00400018, 0, 0, 1, 31));
        vt.push_back(mk(1, 32'h120, rtype(5'd1, 5'd0, 5'd0, 6'h08), 32'h44, 32'h99,
                        1, 1, 0, 1, 32'h44, 0, 0, 0, 0));
        vt.push_back(mk(1, 32'h10, rtype(5'd1, 5'd0, 5'd2, 6'h09), 32'h44, 32'h99,
                        1, 1, 0, 1, 32'h18, 0, 0, 1, 2));
        vt.push_back(mk(1, 32'h124, rtype(5'd1, 5'd2, 5'd0, 6'h21), 5, 7,
                        1, 1, 0, 1, 5, 7, 0, 0, 0));
        // $0 immunity with a load writing $0 in EX
        vt.push_back(fw(mk(1, 32'h128, rtype(5'd0, 5'd0, 5'd3, 6'h21), 32'h9, 32'h9,
                           1, 1, 0, 1, 0, 0, 0, 1, 3), 1, 0, 32'hFFFF, 1, 0, 0, 0));
        // ADDIU $4: rt is the destination, so a load into $4 is no hazard
        vt.push_back(fw(mk(1, 32'h12C, itype(6'h09, 5'd1, 5'd4, 16'd1), 32'h20, 32'h0,
                           1, 0, 0, 1, 32'h20, 0, 1, 1, 4), 1, 4, 32'hDEAD, 1, 0, 0, 0));
        // Load-use on rt only
        vt.push_back(fw(mk(1, 32'h130, rtype(5'd1, 5'd4, 5'd5, 6'h21), 1, 2,
                           1, 1, 1, 0, 0, 0, 0, 0, 0), 1, 4, 32'hDEAD, 1, 0, 0, 0));
        // Load-use on both, then MEM forwarding of the loaded value
        vt.push_back(fw(mk(1, 32'h134, rtype(5'd4, 5'd4, 5'd5, 6'h21), 1, 2,
                           1, 1, 1, 0, 0, 0, 0, 0, 0), 1, 4, 32'hDEAD, 1, 0, 0, 0));
        vt.push_back(fw(mk(1, 32'h134, rtype(5'd4, 5'd4, 5'd5, 6'h21), 1, 2,
                           1, 1, 0, 1, 32'h1234, 32'h1234, 0, 1, 5), 0, 0, 0, 0, 1, 4, 32'h1234));
        // Empty IF/ID: no reads, no write, not valid
        vt.push_back(mk(0, 32'h138, addu3, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        reset = 1'b1;
        drive(vt[0], 1'b0, 1'b0);
        #3;
        chk_ex("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.imm", ex_immediate, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vt[i]) apply(i, vt[i]);

        // stall_in alone: ID/EX holds for 3 cycles while ID changes
        base = vt[0];
        apply(100, base);
        other = vt[4];
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(other, 1'b1, 1'b0);
            #1;
            chk($sformatf("hold%0d.stall", c), 32'(stall_request), 32'h1);
            @(posedge clock);
            #1;
            chk_ex($sformatf("hold%0d", c), 1, 32'h100, addu3, 5, 7, 1, 3);
            chk($sformatf("hold%0d.imm", c), ex_immediate, 32'h0);
        end

        // Flush together with stall: bubble wins
        @(negedge clock);
        drive(other, 1'b1, 1'b1);
        #1;
        chk("flst.stall", 32'(stall_request), 32'h1);
        @(posedge clock);
        #1;
        chk_ex("flst", 0, 0, 0, 0, 0, 0, 0);

        // Flush alone does not raise stall_request
        apply(101, base);
        @(negedge clock);
        drive(other, 1'b0, 1'b1);
        #1;
        chk("fl.stall", 32'(stall_request), 32'h0);
        @(posedge clock);
        #1;
        chk_ex("fl", 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle
        apply(102, base);
        @(negedge clock);
        drive(base, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk_ex("areset", 0, 0, 0, 0, 0, 0, 0);
        chk("areset.rf_en_a", 32'(rf_read_enable_a), 32'h1);
        chk("areset.rf_addr_b", 32'(rf_read_address_b), 32'h2);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_ex("after_reset", 1, 32'h100, addu3, 5, 7, 1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
